// File: rtl/rst_seq.sv
// Reset release sequencer: releases DDR2 interface, then peripherals, then CPU,
// gated on PLL lock and DDR2 calibration, re-sequencing on lock loss or soft reset.
module rst_seq #(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_FILTER   = 8,
    parameter int CALIB_TIMEOUT = 1048576
) (
    input  logic       wb_clk,
    input  logic       wb_rst_i,
    input  logic       locked_mcm,
    input  logic       ddr2_calib_done_i,
    input  logic       soft_rst_req_i,
    output logic       ddr2_if_rst_o,
    output logic       periph_rst_o,
    output logic       cpu_rst_o,
    output logic       sys_ready_o,
    output logic       calib_timeout_o,
    output logic [2:0] state_o
);

    // state      | meaning
    // HOLD       | all resets asserted for HOLD_CYCLES
    // WAIT_LOCK  | all resets asserted, filtering locked_mcm
    // WAIT_CALIB | DDR2 interface released, waiting for calibration
    // REL_PERIPH | peripherals released, CPU held for HOLD_CYCLES
    // RUN        | everything released
    localparam logic [2:0] S_HOLD       = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] S_WAIT_CALIB = 3'd2;
    localparam logic [2:0] S_REL_PERIPH = 3'd3;
    localparam logic [2:0] S_RUN        = 3'd4;

    localparam int MAX_HL = (HOLD_CYCLES > LOCK_FILTER) ? HOLD_CYCLES : LOCK_FILTER;
    localparam int MAX_P  = (MAX_HL > CALIB_TIMEOUT) ? MAX_HL : CALIB_TIMEOUT;
    localparam int CW     = $clog2(MAX_P) + 1;
    localparam int FW     = $clog2(LOCK_FILTER) + 1;

    logic [2:0]    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [FW-1:0] filt, filt_next;
    logic          abort, lock_ok, cnt_tc, timeout_set;
    logic          ddr2_next, periph_next, cpu_next, ready_next;

    assign abort   = ~locked_mcm | soft_rst_req_i;
    assign cnt_tc  = (cnt == CW'(1));
    assign lock_ok = (filt_next == FW'(LOCK_FILTER));
    assign state_o = state;

    always_ff @(posedge wb_clk) begin
        if (wb_rst_i) begin
            state           <= S_HOLD;
            cnt             <= '0;
            filt            <= '0;
            calib_timeout_o <= 1'b0;
            ddr2_if_rst_o   <= 1'b1;
            periph_rst_o    <= 1'b1;
            cpu_rst_o       <= 1'b1;
            sys_ready_o     <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            filt            <= filt_next;
            calib_timeout_o <= calib_timeout_o | timeout_set;
            ddr2_if_rst_o   <= ddr2_next;
            periph_rst_o    <= periph_next;
            cpu_rst_o       <= cpu_next;
            sys_ready_o     <= ready_next;
        end
    end

    always_comb begin
        state_next  = state;
        timeout_set = 1'b0;
        filt_next   = '0;
        if (state == S_WAIT_LOCK && locked_mcm)
            filt_next = (filt == FW'(LOCK_FILTER)) ? filt : filt + FW'(1);
        case (state)
            S_HOLD:      if (cnt_tc) state_next = S_WAIT_LOCK;
            S_WAIT_LOCK: if (lock_ok) state_next = S_WAIT_CALIB;
            S_WAIT_CALIB: begin
                if (abort)                  state_next = S_HOLD;
                else if (ddr2_calib_done_i) state_next = S_REL_PERIPH;
                else if (cnt_tc) begin
                    state_next  = S_HOLD;
                    timeout_set = 1'b1;
                end
            end
            S_REL_PERIPH: begin
                if (abort)       state_next = S_HOLD;
                else if (cnt_tc) state_next = S_RUN;
            end
            S_RUN:       if (abort) state_next = S_HOLD;
            default:     state_next = S_HOLD;
        endcase

        // Timed states exit when the counter reaches 1. A zero count in HOLD only
        // happens straight out of wb_rst_i, where the first cycle is already spent.
        cnt_next = cnt;
        if (state_next != state) begin
            case (state_next)
                S_HOLD:       cnt_next = CW'(HOLD_CYCLES);
                S_WAIT_CALIB: cnt_next = CW'(CALIB_TIMEOUT);
                S_REL_PERIPH: cnt_next = CW'(HOLD_CYCLES);
                default:      cnt_next = '0;
            endcase
        end else if (state == S_HOLD && cnt == '0) begin
            cnt_next = CW'(HOLD_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_comb begin
        ddr2_next   = 1'b1;
        periph_next = 1'b1;
        cpu_next    = 1'b1;
        ready_next  = 1'b0;
        case (state_next)
            S_WAIT_CALIB: ddr2_next = 1'b0;
            S_REL_PERIPH: begin
                ddr2_next   = 1'b0;
                periph_next = 1'b0;
            end
            S_RUN: begin
                ddr2_next   = 1'b0;
                periph_next = 1'b0;
                cpu_next    = 1'b0;
                ready_next  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: nominal release timing, lock filter, calibration
// timeout retry, lock loss, soft reset precedence and synchronous reset.
module tb_rst_seq;

    logic       wb_clk = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic       locked_mcm = 1'b1;
    logic       ddr2_calib_done_i = 1'b1;
    logic       soft_rst_req_i = 1'b0;
    logic       ddr2_if_rst_o, periph_rst_o, cpu_rst_o, sys_ready_o, calib_timeout_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rst_seq #(.HOLD_CYCLES(16), .LOCK_FILTER(8), .CALIB_TIMEOUT(64)) dut (
        .wb_clk            (wb_clk),
        .wb_rst_i          (wb_rst_i),
        .locked_mcm        (locked_mcm),
        .ddr2_calib_done_i (ddr2_calib_done_i),
        .soft_rst_req_i    (soft_rst_req_i),
        .ddr2_if_rst_o     (ddr2_if_rst_o),
        .periph_rst_o      (periph_rst_o),
        .cpu_rst_o         (cpu_rst_o),
        .sys_ready_o       (sys_ready_o),
        .calib_timeout_o   (calib_timeout_o),
        .state_o           (state_o)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
        cyc++;
    endtask

    // ticks until state_o == target; returns number of ticks taken, or -1 on expiry
    task automatic wait_state(input logic [2:0] target, input int budget, output int n);
        n = 0;
        while (state_o != target && n < budget) begin
            tick();
            n++;
        end
        if (state_o != target) begin
            chk("wait_state_expired", 32'(state_o), 32'(target));
            n = -1;
        end
    endtask

    function automatic logic [3:0] rsts();
        return {ddr2_if_rst_o, periph_rst_o, cpu_rst_o, sys_ready_o};
    endfunction

    int n;
    int ddr2_fall, periph_fall, cpu_fall, ready_rise;
    logic [14:0] seq;
    logic [2:0]  last_state;

    initial begin
        // Test 1: nominal power-up, cycle 0 is the cycle after the reset edge
        repeat (3) tick();
        chk("reset_rsts", 32'(rsts()), 32'b1110);
        chk("reset_state", 32'(state_o), 0);
        chk("reset_timeout", 32'(calib_timeout_o), 0);
        wb_rst_i = 1'b0;
        cyc = 0;
        ddr2_fall = -1; periph_fall = -1; cpu_fall = -1; ready_rise = -1;
        seq = 15'(0);
        last_state = 3'd0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ddr2_fall < 0 && !ddr2_if_rst_o) ddr2_fall = cyc;
            if (periph_fall < 0 && !periph_rst_o) periph_fall = cyc;
            if (cpu_fall < 0 && !cpu_rst_o) cpu_fall = cyc;
            if (ready_rise < 0 && sys_ready_o) ready_rise = cyc;
            if (state_o != last_state) begin
                seq = {seq[11:0], state_o};
                last_state = state_o;
            end
        end
        chk("t1_ddr2_fall", 32'(ddr2_fall), 24);
        chk("t1_periph_fall", 32'(periph_fall), 25);
        chk("t1_cpu_fall", 32'(cpu_fall), 41);
        chk("t1_ready_rise", 32'(ready_rise), 41);
        chk("t1_state_seq", 32'(seq), 32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));

        // Test 2: lock glitch filter
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        locked_mcm = 1'b0;
        ddr2_calib_done_i = 1'b0;
        wait_state(3'd1, 30, n);
        chk("t2_hold_len", 32'(n), 16);
        locked_mcm = 1'b1;
        repeat (7) tick();
        chk("t2_after7_state", 32'(state_o), 1);
        locked_mcm = 1'b0;
        tick();
        chk("t2_glitch_state", 32'(state_o), 1);
        chk("t2_glitch_rsts", 32'(rsts()), 32'b1110);
        locked_mcm = 1'b1;
        repeat (7) tick();
        chk("t2_refilter7_state", 32'(state_o), 1);
        chk("t2_refilter7_rsts", 32'(rsts()), 32'b1110);
        tick();
        chk("t2_calib_state", 32'(state_o), 2);
        chk("t2_calib_rsts", 32'(rsts()), 32'b0110);

        // Test 3: calibration timeout, then retry succeeds
        repeat (63) tick();
        chk("t3_pre_to_state", 32'(state_o), 2);
        chk("t3_pre_to_flag", 32'(calib_timeout_o), 0);
        tick();
        chk("t3_to_state", 32'(state_o), 0);
        chk("t3_to_flag", 32'(calib_timeout_o), 1);
        chk("t3_to_ddr2", 32'(ddr2_if_rst_o), 1);
        ddr2_calib_done_i = 1'b1;
        wait_state(3'd4, 60, n);
        chk("t3_retry_len", 32'(n), 41);
        chk("t3_run_flag", 32'(calib_timeout_o), 1);
        chk("t3_run_rsts", 32'(rsts()), 32'b0001);

        // Test 4: lock loss in RUN
        locked_mcm = 1'b0;
        tick();
        locked_mcm = 1'b1;
        chk("t4_rsts", 32'(rsts()), 32'b1110);
        chk("t4_state", 32'(state_o), 0);
        wait_state(3'd4, 60, n);
        chk("t4_reseq_len", 32'(n), 41);

        // Test 5: soft reset in RUN, ignored in WAIT_LOCK, beats done in WAIT_CALIB
        soft_rst_req_i = 1'b1;
        tick();
        soft_rst_req_i = 1'b0;
        chk("t5_run_state", 32'(state_o), 0);
        chk("t5_run_ready", 32'(sys_ready_o), 0);
        wait_state(3'd1, 30, n);
        chk("t5_hold_len", 32'(n), 16);
        repeat (3) tick();
        soft_rst_req_i = 1'b1;
        tick();
        soft_rst_req_i = 1'b0;
        chk("t5_wl_state", 32'(state_o), 1);
        repeat (3) tick();
        chk("t5_wl7_state", 32'(state_o), 1);
        tick();
        chk("t5_wl8_state", 32'(state_o), 2);
        soft_rst_req_i = 1'b1;
        tick();
        soft_rst_req_i = 1'b0;
        chk("t5_prec_state", 32'(state_o), 0);
        chk("t5_prec_rsts", 32'(rsts()), 32'b1110);

        // Test 6: synchronous reset during REL_PERIPH
        wait_state(3'd3, 60, n);
        chk("t6_pre_flag", 32'(calib_timeout_o), 1);
        #3;
        wb_rst_i = 1'b1;
        #2;
        chk("t6_noasync_state", 32'(state_o), 3);
        chk("t6_noasync_periph", 32'(periph_rst_o), 0);
        tick();
        wb_rst_i = 1'b0;
        chk("t6_rsts", 32'(rsts()), 32'b1110);
        chk("t6_state", 32'(state_o), 0);
        chk("t6_flag", 32'(calib_timeout_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset release sequencer that consumes the board-level Wishbone reset and the clock-manager lock, and releases downstream reset domains in a fixed order: DDR2 interface, then peripherals, then CPU.
- Sits between the reset generator and the SoC top.
- Gates each release on the prerequisite handshake (PLL lock filter, DDR2 calibration done), re-sequences on lock loss or a software reset request, and reports progress and calibration timeout.

Parameters:
- HOLD_CYCLES, 16: cycles all resets stay asserted in HOLD; also the delay between peripheral and CPU release (min 2).
- LOCK_FILTER, 8: consecutive cycles locked_mcm must be high before lock is accepted (min 1).
- CALIB_TIMEOUT, 1048576: max cycles spent in WAIT_CALIB before a timeout retry (min 2).

Ports:
- wb_clk  input  1  sole clock.
- wb_rst_i  input  1  synchronous, active-high reset.
- locked_mcm  input  1  clock manager lock, level, synchronous to wb_clk.
- ddr2_calib_done_i  input  1  DDR2 controller calibration complete, level.
- soft_rst_req_i  input  1  single-cycle software reset request pulse.
- ddr2_if_rst_o  output  1  DDR2 interface reset, active high.
- periph_rst_o  output  1  peripheral/Wishbone slave reset, active high.
- cpu_rst_o  output  1  CPU reset, active high.
- sys_ready_o  output  1  high only in RUN.
- calib_timeout_o  output  1  sticky; set on any calibration timeout.
- state_o  output  3  current state encoding (debug).

Behaviour:
- States and encodings: HOLD=0, WAIT_LOCK=1, WAIT_CALIB=2, REL_PERIPH=3, RUN=4. Values 5–7 are unreachable; if decoded, go to HOLD.
- All outputs are registered and are a pure function of the current state, plus the sticky flag.
  - HOLD, WAIT_LOCK: ddr2=1, periph=1, cpu=1.
  - WAIT_CALIB: ddr2=0, periph=1, cpu=1.
  - REL_PERIPH: ddr2=0, periph=0, cpu=1.
  - RUN: all 0, sys_ready=1.
- Reset (wb_rst_i=1 at a clock edge):
  - state=HOLD, counter=0, lock filter=0, calib_timeout_o=0.
  - Outputs next cycle: ddr2/periph/cpu=1, sys_ready=0, state_o=0.
  - wb_rst_i overrides every other input, in any state.
- Single shared down-counter, width clog2 of the largest parameter plus 1; it is loaded on every state entry.
- HOLD: stay exactly HOLD_CYCLES cycles, then go to WAIT_LOCK. locked_mcm is ignored here.
- WAIT_LOCK:
  - Lock filter counts consecutive cycles with locked_mcm=1 and clears on any 0.
  - On the cycle the filter reaches LOCK_FILTER, go to WAIT_CALIB.
  - With locked_mcm held high from entry, WAIT_LOCK lasts exactly LOCK_FILTER cycles.
- WAIT_CALIB:
  - ddr2_calib_done_i=1 sampled → REL_PERIPH on the next cycle.
  - If CALIB_TIMEOUT cycles elapse without done: set calib_timeout_o and go to HOLD, so the DDR2 reset is reasserted and the sequence retries.
  - If done and the timeout terminal count occur in the same cycle, done wins.
- REL_PERIPH: stay exactly HOLD_CYCLES cycles, then go to RUN.
- RUN: stay until an abort event.
- Abort events, valid in WAIT_CALIB, REL_PERIPH and RUN:
  - locked_mcm=0, or soft_rst_req_i=1 → HOLD next cycle. All resets reassert on the cycle after the event is sampled; sys_ready_o drops on that same cycle.
  - Abort has priority over done and over the timeout.
  - In WAIT_LOCK, locked_mcm=0 only clears the filter.
  - soft_rst_req_i is ignored in HOLD and WAIT_LOCK.
- ddr2_calib_done_i dropping in REL_PERIPH or RUN is ignored; the DDR2 controller owns recovery.
- calib_timeout_o is cleared only by wb_rst_i. A later successful calibration does not clear it.
- Minimum release latency from wb_rst_i deassertion, with lock and done already high: HOLD_CYCLES + LOCK_FILTER + 1 + HOLD_CYCLES cycles to sys_ready_o=1.

Test Plan:
1. Nominal power-up with defaults, locked_mcm=1 and calib_done=1 from the start, wb_rst_i released at cycle 0:
   - ddr2_if_rst_o falls at cycle 24.
   - periph_rst_o falls at cycle 25.
   - cpu_rst_o falls and sys_ready_o rises at cycle 41.
   - state_o steps 0,1,2,3,4.
2. Lock glitch filter: in WAIT_LOCK, drive locked_mcm high 7 cycles, low 1 cycle, then high → WAIT_CALIB entered only after 8 further consecutive high cycles; all resets stay high throughout.
3. Calibration timeout with CALIB_TIMEOUT=64 and calib_done held 0:
   - After 64 cycles in WAIT_CALIB, calib_timeout_o=1, state→HOLD, ddr2_if_rst_o=1.
   - Then raise done during the retry → RUN is reached with calib_timeout_o still 1.
4. Lock loss in RUN: drop locked_mcm for 1 cycle → next cycle all three resets are 1, sys_ready_o=0, state_o=0; full re-sequence follows.
5. Soft reset and precedence:
   - soft_rst_req_i pulse in RUN → HOLD next cycle.
   - Pulse in WAIT_LOCK → no effect.
   - Pulse coincident with calib_done in WAIT_CALIB → HOLD, not REL_PERIPH.
6. Synchronous reset mid-sequence: assert wb_rst_i during REL_PERIPH → next edge all resets 1, calib_timeout_o=0, state_o=0; there is no asynchronous response between clock edges.
